imm_extend_stage: RTL and testbench
===================================

Name: imm_extend_stage

Overview:
Parametrised, registered immediate-generation stage for the pipelined CPU's decode path. It takes an IN_W-bit instruction immediate plus a mode and a sideband tag, and produces an OUT_W-bit operand. Four modes are supported: zero-extend, sign-extend, upper-load and branch offset. A 2-entry elastic buffer with valid/ready handshakes on both sides lets decode stalls and flushes be absorbed without losing or duplicating operands.

Parameters:
IN_W, 16, immediate input width
OUT_W, 32, output operand width; must be at least IN_W + BR_SHIFT
BR_SHIFT, 2, left shift applied in branch-offset mode
TAG_W, 5, width of sideband tag (e.g. destination register) carried alongside the result

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  synchronous, active-low reset
flush  input  1  synchronous pipeline flush; discards all buffered entries
in_valid  input  1  upstream presents an immediate
in_ready  output  1  stage can accept an entry this cycle
in_imm  input  IN_W  raw immediate field
in_mode  input  2  00 zero-ext, 01 sign-ext, 10 upper, 11 branch offset
in_tag  input  TAG_W  sideband, passed through unchanged
out_valid  output  1  out_data/out_tag hold a valid entry
out_ready  input  1  downstream consumes the head entry this cycle
out_data  output  OUT_W  extended operand
out_tag  output  TAG_W  tag of the head entry

Behaviour:
- Mode arithmetic. Computed combinationally at the input and stored already extended:
  - 00: upper OUT_W-IN_W bits are 0, low bits = in_imm.
  - 01: upper bits replicate in_imm[IN_W-1].
  - 10: in_imm is placed in bits [OUT_W-1 : OUT_W-IN_W]; the remaining low bits are 0.
  - 11: sign-extend to OUT_W, then shift left BR_SHIFT; zeros fill the bottom, bits shifted out the top are discarded.
- Buffer: 2-entry FIFO (head register plus skid register) with occupancy count 0..2.
- in_ready = (count != 2), derived from registered state only; no combinational path from out_ready.
- out_valid = (count != 0). out_data/out_tag always show the head entry.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Latency: an entry accepted at edge N appears on out_valid/out_data after edge N when the buffer was empty. Minimum latency is 1 cycle; there is no same-cycle bypass.
- Simultaneous push and pop:
  - count 1: count stays 1; the new entry becomes head after the edge.
  - count 2: no push is possible (in_ready=0); count becomes 1 and the skid entry moves to head.
- Push with count 0 or 1 and no pop: count increments and the entry is appended behind the head.
- Entries leave strictly in acceptance order.
- Stability: while out_valid && !out_ready, out_data and out_tag hold constant.
- Priority at the clock edge: reset, then flush, then push/pop.
  - flush: count becomes 0 and a same-cycle input is discarded even if in_valid && in_ready. in_ready is 1 in the following cycle.
- Reset: on any edge with rst_n=0, count=0, out_valid=0, out_data=0, out_tag=0, skid storage=0, and in_ready reads 1 after that edge.
  - Reset mid-transfer drops all buffered entries; no partial output appears.
- Data/tag registers load only on a push or an internal head shift, to reduce toggling. Stale contents beyond count are don't-care but must never be presented with out_valid=1.

Test Plan:
- Defaults, buffer empty, out_ready=1: mode 00, in_imm=0x8001 -> next cycle out_valid=1, out_data=0x00008001; mode 01, 0x8001 -> 0xFFFF8001; mode 01, 0x7FFF -> 0x00007FFF.
- Mode 10, in_imm=0x1234 -> 0x12340000. Mode 11, 0xFFFF -> 0xFFFFFFFC; mode 11, 0x0004 -> 0x00000010. Each tag is echoed exactly.
- Backpressure, out_ready=0, three back-to-back entries A,B,C (tags 1,2,3):
  - A and B are accepted; in_ready=0 after the second edge; C is held upstream.
  - out_data stays A while stalled.
  - Raise out_ready -> A, B, C are delivered in order, with no duplicates or gaps.
- Streaming with out_ready=1 and in_valid=1 for 8 cycles -> throughput of one per cycle, count never exceeds 1, and each output lags its input by 1 cycle.
- With count=2, assert flush with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed input never appears at the output.
- Assert rst_n=0 for one edge while count=2 and out_ready toggling -> out_valid=0, out_data=0, out_tag=0 after that edge; the next accepted entry is delivered normally.

Source files
------------

// File: rtl/imm_extend_stage.sv
// Immediate-generation stage for the decode path: extends an IN_W-bit immediate
// to OUT_W bits by mode and buffers the result in a 2-entry elastic FIFO.
module imm_extend_stage #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] MODE_ZERO  = 2'b00;
  localparam logic [1:0] MODE_SIGN  = 2'b01;
  localparam logic [1:0] MODE_UPPER = 2'b10;

  function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] imm,
                                                  input logic [1:0]      mode);
    logic        [OUT_W-1:0] zx;
    logic signed [OUT_W-1:0] sx;
    logic        [OUT_W-1:0] res;
    zx = OUT_W'(imm);
    sx = OUT_W'($signed(imm));
    case (mode)
      MODE_ZERO:  res = zx;
      MODE_SIGN:  res = sx;
      MODE_UPPER: res = zx << (OUT_W - IN_W);
      default:    res = sx <<< BR_SHIFT;
    endcase
    return res;
  endfunction

  logic [1:0]       count_q, count_d;
  logic [OUT_W-1:0] head_data_q, head_data_d;
  logic [TAG_W-1:0] head_tag_q, head_tag_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  logic [OUT_W-1:0] ext_data;
  logic             push;
  logic             pop;

  // Handshake flags come from registered occupancy only, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_data_q;
  assign out_tag   = head_tag_q;

  assign ext_data = extend_imm(in_imm, in_mode);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_tag_d  = head_tag_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    if (flush) begin
      count_d = 2'd0;
    end else if (push && !pop) begin
      if (count_q == 2'd0) begin
        head_data_d = ext_data;
        head_tag_d  = in_tag;
      end else begin
        skid_data_d = ext_data;
        skid_tag_d  = in_tag;
      end
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      if (count_q == 2'd2) begin
        head_data_d = skid_data_q;
        head_tag_d  = skid_tag_q;
      end
      count_d = count_q - 2'd1;
    end else if (push && pop) begin
      // Only reachable with one entry: the new entry replaces the departing head.
      head_data_d = ext_data;
      head_tag_d  = in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      head_data_q <= '0;
      head_tag_q  <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
    end else begin
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_tag_q  <= head_tag_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Scoreboard bench for imm_extend_stage: expected operands are queued at accept
// time and compared when the DUT hands the head entry downstream.
module tb_imm_extend_stage;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  int n_vec  = 0;
  int n_miss = 0;

  logic [TAG_W+OUT_W-1:0] exp_q[$];

  imm_extend_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .BR_SHIFT(2), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    case (mode)
      2'b00:   return {16'h0000, imm};
      2'b01:   return {{16{imm[15]}}, imm};
      2'b10:   return {imm, 16'h0000};
      default: return {{14{imm[15]}}, imm, 2'b00};
    endcase
  endfunction

  // Inputs are stable from posedge+1 to the next posedge, so the negedge sees
  // exactly the handshakes that the coming edge will act on.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'd0);
        else check("head", 64'({out_tag, out_data}), 64'(exp_q.pop_front()));
      end
      if (in_valid && in_ready)
        exp_q.push_back({in_tag, ref_ext(in_imm, in_mode)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents an entry and returns at posedge+1 after the edge that accepted it.
  task automatic send(input logic [1:0] mode, input logic [15:0] imm, input logic [TAG_W-1:0] tag);
    int waited = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_imm   = imm;
    in_tag   = tag;
    while (!in_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_tag",   64'(out_tag),   64'd0);
    rst_n = 1'b1;
    step();

    // Per-mode vectors, one at a time, with one-cycle latency check.
    begin
      logic [1:0]  modes[6] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11};
      logic [15:0] imms[6]  = '{16'h8001, 16'h8001, 16'h7FFF, 16'h1234, 16'hFFFF, 16'h0004};
      logic [31:0] wants[6] = '{32'h00008001, 32'hFFFF8001, 32'h00007FFF,
                                32'h12340000, 32'hFFFFFFFC, 32'h00000010};
      for (int i = 0; i < 6; i++) begin
        send(modes[i], imms[i], TAG_W'(i + 9));
        in_valid = 1'b0;
        check("lat_valid", 64'(out_valid), 64'd1);
        check("mode_data", 64'(out_data), 64'(wants[i]));
        check("mode_tag",  64'(out_tag),  64'(i + 9));
        step();
        check("lat_drain", 64'(out_valid), 64'd0);
      end
    end

    // Backpressure: A and B fill the buffer, C waits upstream.
    out_ready = 1'b0;
    send(2'b01, 16'hA0A0, 5'd1);
    send(2'b00, 16'hB0B0, 5'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_mode  = 2'b11;
    in_imm   = 16'hC00C;
    in_tag   = 5'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_data", 64'(out_data), 64'(32'hFFFFA0A0));
      check("bp_hold_tag",  64'(out_tag),  64'd1);
      check("bp_hold_rdy",  64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    send(2'b11, 16'hC00C, 5'd3);
    idle(4);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Streaming: one per cycle, occupancy never reaches 2.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_mode  = 2'(i);
      in_imm   = 16'($urandom);
      in_tag   = TAG_W'(i + 16);
      check("stream_rdy", 64'(in_ready), 64'd1);
      step();
      check("stream_vld", 64'(out_valid), 64'd1);
      check("stream_tag", 64'(out_tag),   64'(i + 16));
    end
    idle(2);
    check("stream_drained", 64'(exp_q.size()), 64'd0);

    // Flush with a full buffer and a pending input.
    out_ready = 1'b0;
    send(2'b00, 16'h1111, 5'd4);
    send(2'b00, 16'h2222, 5'd5);
    in_valid = 1'b1;
    in_imm   = 16'h3333;
    in_tag   = 5'd6;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_vld", 64'(out_valid), 64'd0);
    check("flush_rdy", 64'(in_ready),  64'd1);
    // Flush with one entry and an input that would otherwise be accepted.
    send(2'b00, 16'h4444, 5'd7);
    in_valid = 1'b1;
    in_imm   = 16'h5555;
    in_tag   = 5'd8;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("flush1_vld", 64'(out_valid), 64'd0);
    idle(3);

    // Reset while full and out_ready toggling.
    out_ready = 1'b0;
    send(2'b01, 16'h8888, 5'd10);
    send(2'b01, 16'h9999, 5'd11);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    send(2'b10, 16'h7777, 5'd12);
    out_ready = 1'b1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst_vld",  64'(out_valid), 64'd0);
    check("mrst_data", 64'(out_data),  64'd0);
    check("mrst_tag",  64'(out_tag),   64'd0);
    check("mrst_rdy",  64'(in_ready),  64'd1);
    send(2'b10, 16'hBEEF, 5'd13);
    in_valid = 1'b0;
    check("post_rst_data", 64'(out_data), 64'(32'hBEEF0000));
    idle(3);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

endmodule
